a_to_b_link_fifo: RTL and testbench

- Elastic buffer on the module_a -> module_b data path (the a_to_b wire).
- Decouples producer and consumer with a valid/ready handshake on both sides.
- Reports occupancy and peak occupancy for link debug.
- Instantiated by the top level between the producer output and the consumer input, with data width taken from A_TO_B_BITWIDTH.

---
 rtl/a_to_b_link_fifo.sv | 108 ++++++++++
 tb/tb_a_to_b_link_fifo.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/a_to_b_link_fifo.sv
// rtl/a_to_b_link_fifo.sv - elastic valid/ready buffer on the module_a -> module_b link
//
// Purpose: first-word-fall-through FIFO decoupling producer and consumer,
// with current and peak occupancy exported for link debug.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   flush       synchronous clear of contents (peak_level kept)
//   in_valid    producer has data
//   in_ready    buffer can accept (low during reset and when full)
//   in_data     producer payload
//   out_valid   buffer holds at least one word
//   out_ready   consumer accepts head word
//   out_data    head word (zero while empty)
//   level       current entry count, 0..DEPTH
//   peak_level  highest level reached since reset
module a_to_b_link_fifo #(
  parameter int DATA_BITWIDTH = 8,
  parameter int DEPTH         = 4,
  parameter int ADDR_BITWIDTH = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_BITWIDTH-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_BITWIDTH-1:0] out_data,
  output logic [ADDR_BITWIDTH:0]   level,
  output logic [ADDR_BITWIDTH:0]   peak_level
);

  localparam logic [ADDR_BITWIDTH:0]   FULL_LEVEL = (ADDR_BITWIDTH + 1)'(DEPTH);
  localparam logic [ADDR_BITWIDTH:0]   LEVEL_ONE  = (ADDR_BITWIDTH + 1)'(1);
  localparam logic [ADDR_BITWIDTH-1:0] PTR_ONE    = ADDR_BITWIDTH'(1);

  logic [DATA_BITWIDTH-1:0] mem [DEPTH];
  logic [ADDR_BITWIDTH-1:0] wr_ptr;
  logic [ADDR_BITWIDTH-1:0] rd_ptr;
  logic [ADDR_BITWIDTH:0]   level_q;
  logic [ADDR_BITWIDTH:0]   level_next;
  logic [ADDR_BITWIDTH:0]   peak_q;
  logic                     rst_q;
  logic                     push;
  logic                     pop;

  // in_ready depends on registered state only, so the consumer's out_ready
  // never reaches the producer combinationally. rst_q holds it low for the
  // cycle following reset.
  assign in_ready   = (level_q != FULL_LEVEL) && !rst_q;
  assign out_valid  = (level_q != '0);
  // Gated so the output reads zero while empty instead of stale storage.
  assign out_data   = out_valid ? mem[rd_ptr] : '0;
  assign level      = level_q;
  assign peak_level = peak_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    level_next = level_q;
    if (flush) begin
      level_next = '0;
    end else begin
      case ({push, pop})
        2'b10:   level_next = level_q + LEVEL_ONE;
        2'b01:   level_next = level_q - LEVEL_ONE;
        default: level_next = level_q;
      endcase
    end
  end

  // Storage is not reset; writes are suppressed by reset and flush.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      peak_q  <= '0;
      rst_q   <= 1'b1;
    end else begin
      rst_q   <= 1'b0;
      level_q <= level_next;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        // Pointers wrap naturally at DEPTH (power of two).
        if (push) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
      // level_next never exceeds DEPTH, so the peak saturates there.
      if (level_next > peak_q) begin
        peak_q <= level_next;
      end
    end
  end

endmodule

// File: tb/tb_a_to_b_link_fifo.sv
// tb/tb_a_to_b_link_fifo.sv - randomized self-checking bench for a_to_b_link_fifo
module tb_a_to_b_link_fifo;

  localparam int W = 8;
  localparam int D = 4;
  localparam int A = $clog2(D);

  logic         clk;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [A:0]   level;
  logic [A:0]   peak_level;

  a_to_b_link_fifo #(.DATA_BITWIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level), .peak_level(peak_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: contents as a queue, peak as a running max, and a flag
  // remembering that the previous edge was a reset edge.
  logic [W-1:0] q[$];
  logic [W-1:0] exp_pop[$];
  logic [W-1:0] dut_out[$];
  int           peak = 0;
  bit           rstq = 1'b1;

  function automatic bit exp_in_ready();
    return (q.size() < D) && !rstq;
  endfunction

  // Drives one cycle of inputs after a falling edge, advances to the next
  // falling edge, and updates the model. pushed reports model acceptance.
  task automatic step(input bit v, input logic [W-1:0] d, input bit r,
                      input bit f, input bit rs, output bit pushed);
    bit do_push;
    bit do_pop;
    do_push   = v && exp_in_ready() && !rs && !f;
    do_pop    = (q.size() != 0) && r && !rs && !f;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    rst       = rs;
    if (out_valid === 1'b1 && r && !rs && !f) dut_out.push_back(out_data);
    @(posedge clk);
    if (rs) begin
      q.delete();
      peak = 0;
      rstq = 1'b1;
    end else begin
      rstq = 1'b0;
      if (f) q.delete();
      if (do_pop) exp_pop.push_back(q.pop_front());
      if (do_push) q.push_back(d);
      if (q.size() > peak) peak = q.size();
    end
    pushed = do_push;
    @(negedge clk);
  endtask

  // Head word must hold while the consumer stalls; level never exceeds DEPTH.
  logic         hold_q = 1'b0;
  logic [W-1:0] data_q = '0;
  always @(posedge clk) begin
    if (level !== 'x) begin
      checks++;
      if (level > D) begin
        failures++;
        $display("FAIL level_bound: level=%0d max=%0d", level, D);
      end
    end
    if (hold_q) begin
      checks++;
      if (out_data !== data_q) begin
        failures++;
        $display("FAIL hold_stable: out_data=%0h required=%0h", out_data, data_q);
      end
    end
    hold_q = out_valid && !out_ready && !rst && !flush;
    data_q = out_data;
  end

  task automatic test_reset();
    bit p;
    step(0, 0, 0, 0, 1, p);
    step(0, 0, 0, 0, 1, p);
    checks += 5;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %0b required 0", out_valid); end
    if (level !== '0) begin failures++; $display("FAIL reset_level: got %0d required 0", level); end
    if (peak_level !== '0) begin failures++; $display("FAIL reset_peak: got %0d required 0", peak_level); end
    if (out_data !== '0) begin failures++; $display("FAIL reset_out_data: got %0h required 0", out_data); end
    if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %0b required 0", in_ready); end
    step(0, 0, 0, 0, 0, p);
    checks += 2;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready: got %0b required 1", in_ready); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL post_reset_out_valid: got %0b required 0", out_valid); end
  endtask

  task automatic test_fill_drain();
    bit p;
    logic [W-1:0] want [5];
    want = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    dut_out.delete();
    for (int i = 0; i < 4; i++) step(1, want[i], 0, 0, 0, p);
    checks += 2;
    if (level !== 3'd4) begin failures++; $display("FAIL full_level: got %0d required 4", level); end
    if (in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready: got %0b required 0", in_ready); end
    step(1, want[4], 0, 0, 0, p);
    checks++;
    if (level !== 3'd4) begin failures++; $display("FAIL full_held: level %0d required 4", level); end
    // Pop at full: only the pop happens, in_ready returns next cycle.
    step(1, want[4], 1, 0, 0, p);
    checks += 2;
    if (level !== 3'd3) begin failures++; $display("FAIL full_pop_level: got %0d required 3", level); end
    if (in_ready !== 1'b1) begin failures++; $display("FAIL full_pop_in_ready: got %0b required 1", in_ready); end
    step(1, want[4], 1, 0, 0, p);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, p);
    checks += 3;
    if (level !== '0) begin failures++; $display("FAIL drain_level: got %0d required 0", level); end
    if (peak_level !== 3'd4) begin failures++; $display("FAIL drain_peak: got %0d required 4", peak_level); end
    if (dut_out.size() != 5) begin failures++; $display("FAIL drain_count: got %0d required 5", dut_out.size()); end
    for (int i = 0; i < 5 && i < dut_out.size(); i++) begin
      checks++;
      if (dut_out[i] !== want[i]) begin failures++; $display("FAIL drain_order[%0d]: got %0h required %0h", i, dut_out[i], want[i]); end
    end
  endtask

  task automatic test_streaming();
    bit p;
    dut_out.delete();
    for (int i = 0; i < 64; i++) begin
      step(1, W'(i), 1, 0, 0, p);
      checks += 2;
      if (level !== 3'd1) begin failures++; $display("FAIL stream_level[%0d]: got %0d required 1", i, level); end
      if (out_data !== W'(i)) begin failures++; $display("FAIL stream_head[%0d]: got %0h required %0h", i, out_data, W'(i)); end
    end
    step(0, 0, 1, 0, 0, p);
    checks++;
    if (dut_out.size() != 64) begin failures++; $display("FAIL stream_count: got %0d required 64", dut_out.size()); end
    for (int i = 0; i < 64 && i < dut_out.size(); i++) begin
      checks++;
      if (dut_out[i] !== W'(i)) begin failures++; $display("FAIL stream_order[%0d]: got %0h required %0h", i, dut_out[i], W'(i)); end
    end
  endtask

  task automatic test_backpressure();
    bit p;
    int k = 0;
    int cyc = 0;
    dut_out.delete();
    while (k < 4) begin
      step(1, W'(8'h40 + k), 0, 0, 0, p);
      if (p) k++;
    end
    while (dut_out.size() < 40 && cyc < 400) begin
      checks += 2;
      if (level !== 3'(q.size())) begin failures++; $display("FAIL bp_level: got %0d required %0d", level, q.size()); end
      if (in_ready !== exp_in_ready()) begin failures++; $display("FAIL bp_in_ready: got %0b required %0b level=%0d", in_ready, exp_in_ready(), level); end
      step(1, W'(8'h40 + k), (cyc % 3) == 0, 0, 0, p);
      if (p) k++;
      cyc++;
    end
    for (int i = 0; i < 8 && q.size() != 0; i++) step(0, 0, 1, 0, 0, p);
    checks += 2;
    if (level !== '0) begin failures++; $display("FAIL bp_drained: level %0d required 0", level); end
    if (dut_out.size() != k) begin failures++; $display("FAIL bp_count: got %0d required %0d", dut_out.size(), k); end
    for (int i = 0; i < dut_out.size(); i++) begin
      checks++;
      if (dut_out[i] !== W'(8'h40 + i)) begin failures++; $display("FAIL bp_order[%0d]: got %0h required %0h", i, dut_out[i], W'(8'h40 + i)); end
    end
  endtask

  task automatic test_flush();
    bit p;
    step(0, 0, 0, 0, 1, p);
    step(0, 0, 0, 0, 0, p);
    step(1, 8'hA1, 0, 0, 0, p);
    step(1, 8'hA2, 0, 0, 0, p);
    step(1, 8'hA3, 0, 0, 0, p);
    checks++;
    if (level !== 3'd3) begin failures++; $display("FAIL flush_pre_level: got %0d required 3", level); end
    step(1, 8'hA4, 1, 1, 0, p);
    checks += 4;
    if (level !== '0) begin failures++; $display("FAIL flush_level: got %0d required 0", level); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid: got %0b required 0", out_valid); end
    if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready: got %0b required 1", in_ready); end
    if (peak_level !== 3'd3) begin failures++; $display("FAIL flush_peak: got %0d required 3", peak_level); end
    step(1, 8'hB0, 0, 0, 0, p);
    checks += 2;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL flush_next_valid: got %0b required 1", out_valid); end
    if (out_data !== 8'hB0) begin failures++; $display("FAIL flush_next_data: got %0h required b0", out_data); end
    step(0, 0, 1, 0, 0, p);
  endtask

  task automatic test_reset_mid();
    bit p;
    step(1, 8'hC0, 0, 0, 0, p);
    step(1, 8'hC1, 0, 0, 0, p);
    step(1, 8'hC2, 1, 0, 0, p);
    step(1, 8'hC3, 1, 0, 0, p);
    checks++;
    if (level !== 3'd2) begin failures++; $display("FAIL mid_pre_level: got %0d required 2", level); end
    step(1, 8'hC4, 1, 0, 1, p);
    checks += 4;
    if (level !== '0) begin failures++; $display("FAIL mid_level: got %0d required 0", level); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_out_valid: got %0b required 0", out_valid); end
    if (peak_level !== '0) begin failures++; $display("FAIL mid_peak: got %0d required 0", peak_level); end
    if (in_ready !== 1'b0) begin failures++; $display("FAIL mid_in_ready: got %0b required 0", in_ready); end
    dut_out.delete();
    step(0, 0, 1, 0, 0, p);
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_in_ready_after: got %0b required 1", in_ready); end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 0, 0, p);
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_stale_valid[%0d]: got %0b required 0", i, out_valid); end
    end
    checks++;
    if (dut_out.size() != 0) begin failures++; $display("FAIL mid_emitted: got %0d words required 0", dut_out.size()); end
  endtask

  task automatic test_random();
    bit p;
    dut_out.delete();
    exp_pop.delete();
    for (int i = 0; i < 400; i++) begin
      checks += 5;
      if (level !== 3'(q.size())) begin failures++; $display("FAIL rnd_level[%0d]: got %0d required %0d", i, level, q.size()); end
      if (out_valid !== (q.size() != 0)) begin failures++; $display("FAIL rnd_out_valid[%0d]: got %0b required %0b", i, out_valid, q.size() != 0); end
      if (out_data !== ((q.size() != 0) ? q[0] : W'(0))) begin failures++; $display("FAIL rnd_out_data[%0d]: got %0h required %0h", i, out_data, (q.size() != 0) ? q[0] : W'(0)); end
      if (in_ready !== exp_in_ready()) begin failures++; $display("FAIL rnd_in_ready[%0d]: got %0b required %0b", i, in_ready, exp_in_ready()); end
      if (peak_level !== 3'(peak)) begin failures++; $display("FAIL rnd_peak[%0d]: got %0d required %0d", i, peak_level, peak); end
      step($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 2) != 0,
           $urandom_range(0, 29) == 0, $urandom_range(0, 59) == 0, p);
    end
    checks++;
    if (dut_out.size() != exp_pop.size()) begin failures++; $display("FAIL rnd_pop_count: got %0d required %0d", dut_out.size(), exp_pop.size()); end
    for (int i = 0; i < dut_out.size() && i < exp_pop.size(); i++) begin
      checks++;
      if (dut_out[i] !== exp_pop[i]) begin failures++; $display("FAIL rnd_pop[%0d]: got %0h required %0h", i, dut_out[i], exp_pop[i]); end
    end
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_fill_drain();
    test_streaming();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule
